inv_cipher_seq: RTL and testbench
=================================

INV_CIPHER_SEQ -- requirements
Module: inv_cipher_seq

Interface
REQ-001 The block SHALL have parameter Nr, default 10, meaning number of AES rounds (10/12/14).
REQ-002 The block SHALL have parameter Nk, default 4, meaning key length in 32-bit words (4/6/8); it SHALL be consistent with Nr (Nr = Nk+6).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  ciphertext and key schedule present.
REQ-006 in_ready  output  1  block can accept a new block.
REQ-007 ciphertext  input  128  block to decrypt; byte 0 in bits [127:120].
REQ-008 w  input  128*(Nr+1)  expanded key schedule; round key r at w[r*128 +: 128].
REQ-009 abort  input  1  synchronous cancel of the current operation.
REQ-010 out_valid  output  1  plaintext valid.
REQ-011 out_ready  input  1  consumer accepts plaintext.
REQ-012 plaintext  output  128  decrypted block, same byte order as ciphertext.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 round_idx  output  4  round key index consumed this cycle (debug/key-memory address).

Function
REQ-015 The block SHALL be an iterative inverse cipher: one 128-bit state register, one combinational round datapath reused every cycle (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns, in FIPS-197 InvCipher order).
REQ-016 The state machine SHALL have states IDLE, ROUND, FINAL, DONE.
REQ-017 in_ready SHALL equal 1 only in IDLE; the accept event is in_valid & in_ready at a rising edge.
REQ-018 On accept: state <= ciphertext XOR w[Nr]; round counter <= Nr-1; go to ROUND (or FINAL if Nr-1 = 0, not legal for AES).
REQ-019 In ROUND with counter r: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), w[r])); if r = 1 go to FINAL, else r <= r-1.
REQ-020 In FINAL: state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), w[0]); go to DONE.
REQ-021 round_idx SHALL show Nr in IDLE, r in ROUND, 0 in FINAL and DONE.
REQ-022 Latency: out_valid SHALL rise exactly Nr clock edges after the accept edge (10 for AES-128, 14 for AES-256).
REQ-023 In DONE: out_valid = 1, plaintext = state register; both held stable until out_valid & out_ready at an edge, then go to IDLE.
REQ-024 If out_ready is already high when DONE is entered, transfer SHALL complete at the next edge (one out_valid cycle).
REQ-025 No accept SHALL occur in DONE; a new block is accepted no earlier than the cycle after the output transfer.
REQ-026 in_valid while busy SHALL be ignored; ciphertext and w SHALL only be sampled as specified; w SHALL be held stable by the source while busy (block does not latch it).
REQ-027 abort in ROUND, FINAL or DONE SHALL return to IDLE at the next edge, deassert out_valid, and discard the result; abort in IDLE has priority over in_valid (no accept).
REQ-028 plaintext SHALL be driven from the state register at all times; its value is meaningful only while out_valid = 1.

Reset
REQ-029 reset high SHALL asynchronously force IDLE, state register = 0, counter = 0, out_valid = 0, busy = 0, in_ready = 1 (once reset deasserted), round_idx = Nr.
REQ-030 reset mid-operation SHALL discard the operation with no output transfer; first accept is possible on the first edge after reset deasserts.

Verification
REQ-031 AES-128 FIPS-197 C.1: key 000102..0f expanded, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid high 10 edges after accept, plaintext 00112233445566778899aabbccddeeff, one out_valid cycle.
REQ-032 Nr=14, Nk=8 FIPS-197 C.3: key 000102..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233445566778899aabbccddeeff after 14 edges.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid -> plaintext and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 Abort at round_idx=5 -> IDLE next edge, out_valid never asserted; next C.1 block decrypts correctly.
REQ-035 Asynchronous reset asserted mid-ROUND (between edges) -> busy=0, out_valid=0 immediately; back-to-back C.1 blocks after reset each complete in 10 edges with correct plaintext.

Source files
------------

// File: rtl/inv_cipher_seq.sv
// inv_cipher_seq: iterative AES inverse cipher (FIPS-197 InvCipher order).
// A single 128-bit state register is updated once per clock by a shared
// combinational round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// The last round skips InvMixColumns.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset
//   in_valid    ciphertext and key schedule present
//   in_ready    high only in IDLE
//   ciphertext  block to decrypt, byte 0 in [127:120]
//   w           expanded key schedule, round key r at w[r*128 +: 128]
//               (must be held stable by the source while busy)
//   abort       synchronous cancel of the current operation
//   out_valid   plaintext valid (DONE)
//   out_ready   consumer accepts plaintext
//   plaintext   state register, meaningful while out_valid = 1
//   busy        high in any state other than IDLE
//   round_idx   round key index used this cycle
module inv_cipher_seq #(
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            ciphertext,
  input  logic [128*(Nr+1)-1:0]   w,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            plaintext,
  output logic                    busy,
  output logic [3:0]              round_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] NR_IDX = 4'(Nr);

  if (Nr != Nk + 6) begin : g_param_check
    $error("inv_cipher_seq: Nr must equal Nk+6");
  end

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse S-box computed rather than tabulated: undo the affine map
  // (rotations 1,3,6 plus constant 0x05), then take the multiplicative
  // inverse as y^254 by square-and-multiply (0 maps to 0 naturally).
  function automatic logic [7:0] inv_sub(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] p;
    logic [7:0] r;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = y;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [1:0]   fsm_reg;
  logic [3:0]   cnt_reg;
  logic [127:0] state_reg;

  logic [127:0] rk_arr [0:Nr];
  logic [127:0] rk;
  logic [7:0]   st_b  [16];
  logic [7:0]   ark_b [16];
  logic [7:0]   mc_b  [16];
  logic [127:0] final_next;
  logic [127:0] round_next;

  for (genvar gi = 0; gi <= Nr; gi++) begin : g_rk
    assign rk_arr[gi] = w[gi*128 +: 128];
  end

  always_comb begin
    round_idx = 4'd0;
    case (fsm_reg)
      IDLE:    round_idx = NR_IDX;
      ROUND:   round_idx = cnt_reg;
      default: round_idx = 4'd0;
    endcase
  end

  // The key mux follows round_idx, so IDLE already presents w[Nr] for
  // the initial AddRoundKey on accept.
  assign rk = rk_arr[round_idx];

  // Byte index k = 4*col + row. InvShiftRows rotates row r right by r,
  // so output (row, col) takes input (row, col - row mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign st_b[gi]  = state_reg[127-8*gi -: 8];
    assign ark_b[gi] = inv_sub(st_b[SRC]) ^ rk[127-8*gi -: 8];
    assign final_next[127-8*gi -: 8] = ark_b[gi];
    assign round_next[127-8*gi -: 8] = mc_b[gi];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_b[4*gi];
    assign a1 = ark_b[4*gi+1];
    assign a2 = ark_b[4*gi+2];
    assign a3 = ark_b[4*gi+3];
    assign mc_b[4*gi]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mc_b[4*gi+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mc_b[4*gi+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mc_b[4*gi+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg   <= IDLE;
      cnt_reg   <= 4'd0;
      state_reg <= 128'd0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          // abort wins over in_valid: no accept in that cycle
          if (in_valid && !abort) begin
            state_reg <= ciphertext ^ rk;
            cnt_reg   <= 4'(Nr - 1);
            fsm_reg   <= (Nr == 1) ? FINAL : ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            fsm_reg <= IDLE;
          end else begin
            state_reg <= round_next;
            if (cnt_reg == 4'd1) fsm_reg <= FINAL;
            else                 cnt_reg <= cnt_reg - 4'd1;
          end
        end
        FINAL: begin
          if (abort) begin
            fsm_reg <= IDLE;
          end else begin
            state_reg <= final_next;
            fsm_reg   <= DONE;
          end
        end
        default: begin
          if (abort || out_ready) fsm_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (fsm_reg == IDLE);
  assign busy      = (fsm_reg != IDLE);
  assign out_valid = (fsm_reg == DONE);
  assign plaintext = state_reg;

endmodule

// File: tb/tb_inv_cipher_seq.sv
// Testbench for inv_cipher_seq. Expected plaintexts come either from
// FIPS-197 constants or from a forward AES cipher model (random key
// schedule, random plaintext -> ciphertext fed to the DUT).
module tb_inv_cipher_seq;

  localparam int NR = 10;
  localparam int NR_B = 14;

  logic          clk;
  logic          reset;
  logic          in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [127:0]  ciphertext, plaintext;
  logic [1407:0] w128;
  logic [3:0]    round_idx;

  logic          in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0]  ciphertext_b, plaintext_b;
  logic [1919:0] w256;
  logic [3:0]    round_idx_b;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] sbox_t [256];

  inv_cipher_seq #(.Nr(10), .Nk(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .w(w128), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy), .round_idx(round_idx)
  );

  inv_cipher_seq #(.Nr(14), .Nk(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .ciphertext(ciphertext_b), .w(w256), .abort(abort_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .plaintext(plaintext_b), .busy(busy_b), .round_idx(round_idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------- reference model (forward AES) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [1919:0] key_exp(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   ww [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] res;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ww[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = ww[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      ww[i] = ww[i-nk] ^ tmp;
    end
    res = '0;
    for (int r = 0; r <= nr; r++) res[r*128 +: 128] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1919:0] wk, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ wk[127-8*k -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ wk[rnd*128 + 127 - 8*k -: 8];
    end
    for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- transaction tasks (start and end at a negedge) ----------------
  task automatic run_block(input logic [127:0] ct, input logic [1919:0] wk,
                           input logic [127:0] exp_pt, input int hold, input string tag);
    int lat;
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    ciphertext = ct;
    w128 = wk[1407:0];
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ciphertext = rand128();
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 3*NR) begin
      chk({tag, "_round_idx"}, 128'(round_idx), 128'((lat < NR-1) ? NR-1-lat : 0));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 128'(lat), 128'(NR));
    chk({tag, "_plaintext"}, plaintext, exp_pt);
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_hold_pt"}, plaintext, exp_pt);
      chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
      in_valid = 1'b1;
      ciphertext = rand128();
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_post_in_ready"}, 128'(in_ready), 128'(1));
    $display("txn %s ct=%h pt=%h lat=%0d hold=%0d", tag, ct, plaintext, lat, hold);
  endtask

  task automatic run_block_b(input logic [127:0] ct, input logic [1919:0] wk,
                             input logic [127:0] exp_pt, input string tag);
    int lat;
    in_valid_b = 1'b1;
    ciphertext_b = ct;
    w256 = wk;
    out_ready_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 3*NR_B) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 128'(lat), 128'(NR_B));
    chk({tag, "_plaintext"}, plaintext_b, exp_pt);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_valid"}, 128'(out_valid_b), 128'(0));
    $display("txn %s ct=%h pt=%h lat=%0d", tag, ct, plaintext_b, lat);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [1919:0] w_c1, w_c3, wr;
    logic [127:0]  pt_r;
    int            seen, guard;

    reset = 1'b0;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; ciphertext = '0; w128 = '0;
    in_valid_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b0; ciphertext_b = '0; w256 = '0;
    build_sbox();
    w_c1 = key_exp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    w_c3 = key_exp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    #1 reset = 1'b1;
    #11;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_round_idx", 128'(round_idx), 128'(NR));
    chk("rst_plaintext", plaintext, 128'd0);
    chk("rst_round_idx_b", 128'(round_idx_b), 128'(NR_B));
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1, consumer ready
    run_block(CT_C1, w_c1, PT_FIPS, 0, "c1");
    // backpressure
    run_block(CT_C1, w_c1, PT_FIPS, 5, "c1_bp");
    // FIPS-197 C.3 on the 14-round instance
    run_block_b(CT_C3, w_c3, PT_FIPS, "c3");

    // abort while idle beats in_valid
    in_valid = 1'b1; abort = 1'b1; ciphertext = CT_C1; w128 = w_c1[1407:0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 128'(busy), 128'(0));

    // abort at round_idx 5
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (round_idx != 4'd5 && guard < 20) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    chk("abort_reach_idx", 128'(round_idx), 128'(5));
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_output", 128'(seen), 128'(0));
    run_block(CT_C1, w_c1, PT_FIPS, 0, "c1_after_abort");

    // asynchronous reset in the middle of ROUND
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_round_idx", 128'(round_idx), 128'(NR));
    @(negedge clk);
    reset = 1'b0;
    run_block(CT_C1, w_c1, PT_FIPS, 0, "c1_after_rst_a");
    run_block(CT_C1, w_c1, PT_FIPS, 0, "c1_after_rst_b");

    // random blocks against the forward-cipher model
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 60; i++) wr[32*i +: 32] = $urandom();
      pt_r = rand128();
      run_block(aes_enc(pt_r, wr, NR), wr, pt_r, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 60; i++) wr[32*i +: 32] = $urandom();
      pt_r = rand128();
      run_block_b(aes_enc(pt_r, wr, NR_B), wr, pt_r, $sformatf("rnd256_%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
